hls_sweep_driver: RTL and testbench

//  Upstream sequencer for a single-result ap_ctrl_hs HLS core (5-bit index in, 7-bit ap_return out).
//  On command, sweeps core_index over a range, issuing one ap_start transaction per index.

---
 rtl/hls_sweep_driver_if.sv | 27 ++
 rtl/hls_sweep_driver.sv | 187 ++++++++++++++++++
 tb/tb_hls_sweep_driver.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hls_sweep_driver_if.sv
// rtl/hls_sweep_driver_if.sv - core ap_ctrl_hs and result-stream bundle for hls_sweep_driver
interface hls_sweep_driver_if #(
    parameter int IDX_W = 5,
    parameter int RET_W = 7
);
    logic             core_start;
    logic [IDX_W-1:0] core_index;
    logic             core_ready;
    logic             core_done;
    logic             core_idle;
    logic [RET_W-1:0] core_return;

    logic             res_valid;
    logic             res_ready;
    logic [IDX_W-1:0] res_index;
    logic [RET_W-1:0] res_data;

    modport master (
        output core_start, core_index, res_valid, res_index, res_data,
        input  core_ready, core_done, core_idle, core_return, res_ready
    );

    modport slave (
        input  core_start, core_index, res_valid, res_index, res_data,
        output core_ready, core_done, core_idle, core_return, res_ready
    );
endinterface

// File: rtl/hls_sweep_driver.sv
// rtl/hls_sweep_driver.sv - sweeps an ap_ctrl_hs core over an index range, streams (index, result) beats
// Optional: define SWEEP_CHECKSUM_EN to add the res_sum running checksum output.
module hls_sweep_driver #(
    parameter int IDX_W       = 5,
    parameter int RET_W       = 7,
    parameter int GAP_CYC     = 10,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             sweep_go,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] last_idx,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             err_timeout,
    hls_sweep_driver_if.master bus
`ifdef SWEEP_CHECKSUM_EN
    ,
    output logic [RET_W+IDX_W-1:0] res_sum
`endif
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAP   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] last_r;
    logic [GW-1:0]    gap_cnt;
    logic [TW-1:0]    to_cnt;
    logic             res_valid_r;
    logic [IDX_W-1:0] res_index_r;
    logic [RET_W-1:0] res_data_r;
    logic             busy_r;
    logic             err_r;

    logic accept_go;
    logic capture;
    logic beat_acc;
    logic abort;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Progress (ready/done) wins over the timeout when both land on the same cycle.
    always_comb begin
        state_nx  = state;
        accept_go = 1'b0;
        capture   = 1'b0;
        beat_acc  = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (sweep_go && bus.core_idle) begin
                    accept_go = 1'b1;
                    state_nx  = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (bus.core_ready) begin
                    if (bus.core_done) begin
                        capture  = 1'b1;
                        state_nx = S_EMIT;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end else if (to_cnt == TO_LAST) begin
                    abort    = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    capture  = 1'b1;
                    state_nx = S_EMIT;
                end else if (to_cnt == TO_LAST) begin
                    abort    = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_EMIT: begin
                if (res_valid_r && bus.res_ready) begin
                    beat_acc = 1'b1;
                    state_nx = (cur == last_r) ? S_FIN : S_GAP;
                end
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Counters idle at zero outside their states, so entering GAP/START always starts from 0.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cur         <= '0;
            last_r      <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            res_valid_r <= 1'b0;
            res_index_r <= '0;
            res_data_r  <= '0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
            to_cnt  <= (state == S_START || state == S_WAIT) ? to_cnt + TW'(1) : '0;

            if (accept_go) begin
                cur    <= first_idx;
                last_r <= last_idx;
                err_r  <= 1'b0;
                busy_r <= 1'b1;
            end
            if (capture) begin
                res_valid_r <= 1'b1;
                res_index_r <= cur;
                res_data_r  <= bus.core_return;
            end
            if (beat_acc) begin
                res_valid_r <= 1'b0;
                if (cur != last_r) begin
                    cur <= cur + IDX_W'(1);
                end
            end
            if (abort) begin
                err_r  <= 1'b1;
                busy_r <= 1'b0;
            end
            if (state == S_FIN) begin
                busy_r <= 1'b0;
            end
        end
    end

`ifdef SWEEP_CHECKSUM_EN
    logic [RET_W+IDX_W-1:0] sum_r;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            sum_r <= '0;
        end else if (accept_go) begin
            sum_r <= '0;
        end else if (beat_acc) begin
            sum_r <= sum_r + {{IDX_W{1'b0}}, res_data_r};
        end
    end

    assign res_sum = sum_r;
`endif

    assign bus.core_start = (state == S_START);
    assign bus.core_index = cur;
    assign bus.res_valid  = res_valid_r;
    assign bus.res_index  = res_index_r;
    assign bus.res_data   = res_data_r;
    assign sweep_busy     = busy_r;
    assign sweep_done     = (state == S_FIN);
    assign err_timeout    = err_r;

endmodule

// File: tb/tb_hls_sweep_driver.sv
// tb/tb_hls_sweep_driver.sv - scoreboard bench for hls_sweep_driver with a 3-cycle model core
module tb_hls_sweep_driver;

    logic       ap_clk = 1'b0;
    logic       ap_rst = 1'b1;
    logic       sweep_go = 1'b0;
    logic [4:0] first_idx = '0;
    logic [4:0] last_idx = '0;
    logic       sweep_busy;
    logic       sweep_done;
    logic       err_timeout;
`ifdef SWEEP_CHECKSUM_EN
    logic [11:0] res_sum;
`endif

    hls_sweep_driver_if #(.IDX_W(5), .RET_W(7)) bus ();

    hls_sweep_driver #(
        .IDX_W(5), .RET_W(7), .GAP_CYC(10), .TIMEOUT_CYC(1000)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .sweep_go    (sweep_go),
        .first_idx   (first_idx),
        .last_idx    (last_idx),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .err_timeout (err_timeout),
        .bus         (bus)
`ifdef SWEEP_CHECKSUM_EN
        ,
        .res_sum     (res_sum)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    // Model core: ready with start, done 3 cycles later, return = idx*3 mod 128.
    logic [1:0] mc_cnt;
    logic [4:0] mc_idx;
    logic       hang = 1'b0;
    logic       idle_kill = 1'b0;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            mc_cnt <= '0;
            mc_idx <= '0;
        end else if (bus.core_start) begin
            mc_cnt <= 2'd3;
            mc_idx <= bus.core_index;
        end else if (mc_cnt != 2'd0) begin
            mc_cnt <= mc_cnt - 2'd1;
        end
    end

    assign bus.core_ready  = bus.core_start;
    assign bus.core_done   = (mc_cnt == 2'd1) && !hang;
    assign bus.core_return = {2'b00, mc_idx} * 7'd3;
    assign bus.core_idle   = (mc_cnt == 2'd0) && !bus.core_start && !idle_kill;

    logic bp = 1'b0;
    int   cyc = 0;
    initial begin
        bus.res_ready = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            cyc++;
            bus.res_ready = bp ? (cyc % 3 == 0) : 1'b1;
        end
    end

    typedef struct {
        int idx;
        int dat;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;
    int    sum_model = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat, checks hold during stalls.
    initial begin
        logic prev_stall;
        int   prev_idx;
        int   prev_dat;
        beat_t e;
        prev_stall = 1'b0;
        prev_idx = 0;
        prev_dat = 0;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", int'(bus.res_valid), 1);
                    check("hold_index", int'(bus.res_index), prev_idx);
                    check("hold_data", int'(bus.res_data), prev_dat);
                end
                prev_stall = bus.res_valid && !bus.res_ready;
                prev_idx = int'(bus.res_index);
                prev_dat = int'(bus.res_data);
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got index %0d data %0d expected none",
                                 bus.res_index, bus.res_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_index", int'(bus.res_index), e.idx);
                        check("beat_data", int'(bus.res_data), e.dat);
                        sum_model = (sum_model + e.dat) % 4096;
                    end
                end
                if (sweep_done) begin
                    done_cnt++;
                    check("done_after_last_beat", exp_q.size(), 0);
`ifdef SWEEP_CHECKSUM_EN
                    check("res_sum_at_done", int'(res_sum), sum_model);
`endif
                end
            end
        end
    end

    task automatic push_range(input int f, input int l);
        int k;
        beat_t b;
        k = f;
        forever begin
            b.idx = k;
            b.dat = (k * 3) & 127;
            exp_q.push_back(b);
            if (k == l) break;
            k = (k + 1) % 32;
        end
    endtask

    task automatic do_go(input int f, input int l);
        @(posedge ap_clk);
        #1;
        first_idx = 5'(f);
        last_idx  = 5'(l);
        sweep_go  = 1'b1;
        @(posedge ap_clk);
        #1;
        sweep_go  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 3000; i++) begin
            @(negedge ap_clk);
            if (done_cnt != d0) break;
        end
        check(name, done_cnt - d0, 1);
        @(negedge ap_clk);
        check({name, "_busy_low"}, int'(sweep_busy), 0);
    endtask

    task automatic run_sweep(input string name, input int f, input int l);
        push_range(f, l);
        sum_model = 0;
        do_go(f, l);
        check({name, "_busy"}, int'(sweep_busy), 1);
        check({name, "_err_clear"}, int'(err_timeout), 0);
        wait_done(name);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(sweep_busy), 0);
        check({tag, "_done"}, int'(sweep_done), 0);
        check({tag, "_err"}, int'(err_timeout), 0);
        check({tag, "_core_start"}, int'(bus.core_start), 0);
        check({tag, "_core_index"}, int'(bus.core_index), 0);
        check({tag, "_res_valid"}, int'(bus.res_valid), 0);
        check({tag, "_res_index"}, int'(bus.res_index), 0);
        check({tag, "_res_data"}, int'(bus.res_data), 0);
    endtask

    initial begin
        int tcnt;
        int d0;
        logic seen;

        repeat (3) @(negedge ap_clk);
        check_all_zero("reset");
        ap_rst = 1'b0;
        repeat (2) @(negedge ap_clk);

        run_sweep("full_ring", 0, 31);
`ifdef SWEEP_CHECKSUM_EN
        check("full_ring_sum", int'(res_sum), 1488);
`endif

        run_sweep("wrap", 30, 1);

        bp = 1'b1;
        run_sweep("backpressure", 4, 12);
        bp = 1'b0;

        run_sweep("single", 17, 17);

        // Core that never completes must trip the timeout after 1000 START+WAIT cycles.
        hang = 1'b1;
        d0 = done_cnt;
        do_go(5, 5);
        tcnt = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge ap_clk);
            if (err_timeout) break;
            if (bus.core_start || tcnt > 0) tcnt++;
        end
        check("timeout_err", int'(err_timeout), 1);
        check("timeout_cycles", tcnt, 1000);
        check("timeout_busy", int'(sweep_busy), 0);
        check("timeout_no_done", done_cnt - d0, 0);
        hang = 1'b0;
        repeat (5) @(negedge ap_clk);
        check("timeout_sticky", int'(err_timeout), 1);
        run_sweep("after_timeout", 2, 3);

        // Reset while beat 7 is on the stream.
        push_range(0, 15);
        d0 = done_cnt;
        do_go(0, 15);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge ap_clk);
            if (bus.res_valid && bus.res_index == 5'd7) begin
                seen = 1'b1;
                break;
            end
        end
        check("reset_reached_beat7", int'(seen), 1);
        #1;
        ap_rst = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (3) @(negedge ap_clk);
        check("midreset_no_done", done_cnt - d0, 0);
        run_sweep("restart", 0, 2);

        // Go pulses while busy or with the core not idle are dropped.
        push_range(8, 10);
        sum_model = 0;
        do_go(8, 10);
        repeat (20) @(negedge ap_clk);
        do_go(20, 25);
        repeat (7) @(negedge ap_clk);
        do_go(1, 1);
        wait_done("ignore_busy_go");
        idle_kill = 1'b1;
        do_go(1, 1);
        repeat (20) @(negedge ap_clk);
        check("ignore_nonidle_busy", int'(sweep_busy), 0);
        check("ignore_nonidle_start", int'(bus.core_start), 0);
        idle_kill = 1'b0;
        run_sweep("after_ignore", 9, 9);

        repeat (5) @(negedge ap_clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("done_total", done_cnt, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
